// File: rtl/product_bcd_display.sv
// Product to BCD converter (sequential double-dabble) with a
// multiplexed active-low 7-segment display driver.
module product_bcd_display #(
  parameter int SCAN_DIV = 25000
) (
  input  logic        mHz,
  input  logic        reset,
  input  logic [7:0]  bin,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q;
  logic [19:0]   scr_q;
  logic [2:0]    cnt_q;
  logic [11:0]   bcd_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q;

  logic [19:0]   scr_adj;
  logic [19:0]   scr_sh;

  always_comb begin
    scr_adj = scr_q;
    if (scr_q[11:8] >= 4'd5)
      scr_adj[11:8] = scr_q[11:8] + 4'd3;
    if (scr_q[15:12] >= 4'd5)
      scr_adj[15:12] = scr_q[15:12] + 4'd3;
    if (scr_q[19:16] >= 4'd5)
      scr_adj[19:16] = scr_q[19:16] + 4'd3;
    scr_sh = scr_adj << 1;
  end

  // done lags the DONE state by one edge so it coincides with IDLE
  always_ff @(posedge mHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            scr_q   <= {12'b0, bin};
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_sh;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            bcd_q   <= scr_sh[19:8];
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge mHz or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + CW'(1);
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [6:0] dec;

  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    an    = 4'b1110;
    case (idx_q)
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        an    = 4'b1101;
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
        an    = 4'b1011;
      end
      default: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
        an    = 4'b1110;
      end
    endcase
  end

  always_comb begin
    case (nib)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  end

  assign seg  = blank ? 7'h7F : dec;
  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display: latency, sweep,
// held start, reset behaviour and display scan.
module tb_product_bcd_display;

  logic        mHz = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  product_bcd_display #(.SCAN_DIV(4)) dut (
    .mHz   (mHz),
    .reset (reset),
    .bin   (bin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .seg   (seg),
    .an    (an)
  );

  always #5 mHz = ~mHz;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // entered at a negedge while the FSM will be IDLE at the next edge
  task automatic conv(input logic [7:0] b, input bit hold,
                      output logic [11:0] r);
    int n;
    bit got;
    bin   = b;
    start = 1'b1;
    @(posedge mHz);
    #1;
    if (!hold) start = 1'b0;
    chk("busy_acc", busy, 1);
    chk("done_acc", done, 0);
    bin = ~b;
    n   = 0;
    got = 0;
    while (!got && n < 15) begin
      @(posedge mHz);
      n++;
      @(negedge mHz);
      if (busy !== 1'b1) chk("busy_run", busy, 1);
      if (done === 1'b1) got = 1;
      else bin = bin ^ 8'h5A;
    end
    chk("latency", n, 9);
    r = bcd;
  endtask

  task automatic scan_check(input logic [6:0] s0,
                            input logic [6:0] s1,
                            input logic [6:0] s2);
    int t;
    logic [3:0] ea;
    logic [6:0] es;
    t = 0;
    while (an !== 4'b1011 && t < 40) begin
      @(negedge mHz);
      t++;
    end
    while (an !== 4'b1110 && t < 40) begin
      @(negedge mHz);
      t++;
    end
    chk("scan_sync", (t < 40), 1);
    for (int i = 0; i < 12; i++) begin
      case (i / 4)
        0: begin ea = 4'b1110; es = s0; end
        1: begin ea = 4'b1101; es = s1; end
        default: begin ea = 4'b1011; es = s2; end
      endcase
      chk("scan_an", an, ea);
      chk("scan_seg", seg, es);
      @(negedge mHz);
    end
  endtask

  logic [11:0] r;
  int bad;
  bit seen;

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'h40);
    @(negedge mHz);
    @(negedge mHz);
    reset = 1'b0;

    conv(8'd225, 0, r);
    chk("bcd_225", r, 12'h225);
    @(posedge mHz);
    @(negedge mHz);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    bad = 0;
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), 1, r);
      if (v == 0)   chk("sw_000", r, 12'h000);
      if (v == 9)   chk("sw_009", r, 12'h009);
      if (v == 100) chk("sw_100", r, 12'h100);
      if (v == 255) chk("sw_255", r, 12'h255);
      if (r !== dec3(v)) bad++;
    end
    start = 1'b0;
    chk("sweep_bad", bad, 0);

    conv(8'd17, 1, r);
    chk("hold_17", r, 12'h017);
    conv(8'd183, 1, r);
    chk("hold_183", r, 12'h183);
    conv(8'd99, 1, r);
    chk("hold_99", r, 12'h099);
    start = 1'b0;

    bin   = 8'd255;
    start = 1'b1;
    @(posedge mHz);
    #1 start = 1'b0;
    repeat (3) @(posedge mHz);
    #3 reset = 1'b1;
    #1;
    chk("mid_bcd", bcd, 12'h000);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_an", an, 4'b1110);
    chk("mid_seg", seg, 7'h40);
    @(negedge mHz);
    reset = 1'b0;

    conv(8'd64, 0, r);
    chk("bcd_064", r, 12'h064);
    bin   = 8'd200;
    start = 1'b1;
    @(posedge mHz);
    #1 start = 1'b0;
    repeat (3) @(posedge mHz);
    #2 reset = 1'b1;
    #1;
    chk("r5_bcd", bcd, 12'h000);
    chk("r5_busy", busy, 0);
    @(negedge mHz);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge mHz);
      if (done === 1'b1) seen = 1;
    end
    chk("r5_nodone", seen, 0);
    chk("r5_bcd_hold", bcd, 12'h000);
    conv(8'd37, 0, r);
    chk("bcd_037", r, 12'h037);

    conv(8'd9, 0, r);
    chk("bcd_009", r, 12'h009);
    scan_check(7'h10, 7'h7F, 7'h7F);
    conv(8'd105, 0, r);
    chk("bcd_105", r, 12'h105);
    scan_check(7'h12, 7'h40, 7'h79);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
